// File: rtl/tile_renderer.sv
// Tile-map pixel generator: x/y/vde in, RGB plus delayed syncs out, 4-clock pipeline.
// Define TILE_RENDERER_CURSOR_EN to add the 2-pixel tile cursor overlay and its inputs.
module tile_renderer #(
    parameter int          H_ACTIVE_START = 192,
    parameter int          V_ACTIVE_START = 41,
    parameter int          Y_ADJ          = 12,
    parameter int          TILE_LOG2      = 5,
    parameter int          N_COLS         = 60,
    parameter int          N_ROWS         = 34,
    parameter int          MAP_AW         = 11,
    parameter int          SPR_W          = 4,
    parameter int          BPP            = 3,
    parameter logic [23:0] BG_COLOR       = 24'hFFFFFF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [11:0]                   x,
    input  logic [11:0]                   y,
    input  logic                          vde,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic                          map_we,
    input  logic [MAP_AW-1:0]             map_addr,
    input  logic [SPR_W-1:0]              map_wdata,
    input  logic                          pal_we,
    input  logic [BPP-1:0]                pal_addr,
    input  logic [23:0]                   pal_wdata,
    output logic [SPR_W+TILE_LOG2-1:0]    rom_addr,
    input  logic [(BPP<<TILE_LOG2)-1:0]   rom_data,
`ifdef TILE_RENDERER_CURSOR_EN
    input  logic                          cursor_en,
    input  logic [6:0]                    cursor_col,
    input  logic [5:0]                    cursor_row,
    input  logic [23:0]                   cursor_color,
`endif
    output logic [7:0]                    R,
    output logic [7:0]                    G,
    output logic [7:0]                    B,
    output logic                          vde_out,
    output logic                          hsync_out,
    output logic                          vsync_out,
    output logic [MAP_AW-1:0]             current_tile
);
    localparam int TILE      = 1 << TILE_LOG2;
    localparam int CW        = 13 - TILE_LOG2;
    localparam int MAP_DEPTH = N_COLS * N_ROWS;
    localparam int PAL_N     = 1 << BPP;
    localparam int LAT       = 4;

    logic [12:0]          lx, ly;
    logic [CW-1:0]        col, row;
    logic                 in_grid0;
    logic [MAP_AW-1:0]    tile0;

    // Negative local coordinates wrap to large values and fall outside the grid.
    assign lx       = {1'b0, x} - 13'(H_ACTIVE_START);
    assign ly       = {1'b0, y} - 13'(V_ACTIVE_START) + 13'(Y_ADJ);
    assign col      = lx[12:TILE_LOG2];
    assign row      = ly[12:TILE_LOG2];
    assign in_grid0 = vde && (32'(col) < N_COLS) && (32'(row) < N_ROWS);
    assign tile0    = MAP_AW'(32'(row) * N_COLS + 32'(col));

    logic [TILE_LOG2-1:0] px1_q, py1_q, px2_q, py2_q, px3_q;
    logic                 in_grid1_q, in_grid2_q, in_grid3_q;
    logic [MAP_AW-1:0]    tile_q;
    logic [SPR_W-1:0]     sprite_q;
    logic [LAT-1:0]       vde_sr_q, hs_sr_q, vs_sr_q;
    logic [23:0]          rgb_q, rgb_d;
    logic [BPP-1:0]       pix_idx;

    logic [SPR_W-1:0]     map_mem [2**MAP_AW];
    logic [23:0]          pal_q   [PAL_N];

    always_ff @(posedge clk) begin
        if (map_we && (32'(map_addr) < MAP_DEPTH))
            map_mem[map_addr] <= map_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PAL_N; i++) pal_q[i] <= 24'h000000;
            pal_q[1] <= 24'h0000FF;
            pal_q[2] <= 24'h00FF00;
            pal_q[4] <= 24'hFF0000;
        end else if (pal_we) begin
            pal_q[pal_addr] <= pal_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px1_q      <= '0;
            py1_q      <= '0;
            in_grid1_q <= 1'b0;
            tile_q     <= '0;
            sprite_q   <= '0;
            px2_q      <= '0;
            py2_q      <= '0;
            in_grid2_q <= 1'b0;
            px3_q      <= '0;
            in_grid3_q <= 1'b0;
            vde_sr_q   <= '0;
            hs_sr_q    <= '0;
            vs_sr_q    <= '0;
            rgb_q      <= '0;
        end else begin
            px1_q      <= lx[TILE_LOG2-1:0];
            py1_q      <= ly[TILE_LOG2-1:0];
            in_grid1_q <= in_grid0;
            if (vde) tile_q <= tile0;
            // A same-cycle write to this address lands after the read, so old data is seen.
            sprite_q   <= map_mem[tile_q];
            px2_q      <= px1_q;
            py2_q      <= py1_q;
            in_grid2_q <= in_grid1_q;
            px3_q      <= px2_q;
            in_grid3_q <= in_grid2_q;
            vde_sr_q   <= {vde_sr_q[LAT-2:0], vde};
            hs_sr_q    <= {hs_sr_q[LAT-2:0], hsync_in};
            vs_sr_q    <= {vs_sr_q[LAT-2:0], vsync_in};
            rgb_q      <= rgb_d;
        end
    end

    // The ROM registers rom_addr on the next edge, so rom_data lines up with stage 3.
    assign rom_addr = {sprite_q, py2_q};

`ifdef TILE_RENDERER_CURSOR_EN
    logic border0, cur0;
    logic cur1_q, cur2_q, cur3_q;

    assign border0 = (lx[TILE_LOG2-1:0] <  TILE_LOG2'(2))
                  || (lx[TILE_LOG2-1:0] >= TILE_LOG2'(TILE-2))
                  || (ly[TILE_LOG2-1:0] <  TILE_LOG2'(2))
                  || (ly[TILE_LOG2-1:0] >= TILE_LOG2'(TILE-2));
    assign cur0 = cursor_en && in_grid0 && border0
               && (col == CW'(cursor_col)) && (row == CW'(cursor_row));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur1_q <= 1'b0;
            cur2_q <= 1'b0;
            cur3_q <= 1'b0;
        end else begin
            cur1_q <= cur0;
            cur2_q <= cur1_q;
            cur3_q <= cur2_q;
        end
    end
`endif

    always_comb begin
        pix_idx = '0;
        for (int i = 0; i < TILE; i++)
            if (px3_q == TILE_LOG2'(i)) pix_idx = rom_data[(TILE-1-i)*BPP +: BPP];
    end

    always_comb begin
        rgb_d = BG_COLOR;
        if (!vde_sr_q[LAT-2])
            rgb_d = '0;
        else if (in_grid3_q && (pix_idx != '0))
            rgb_d = pal_q[pix_idx];
`ifdef TILE_RENDERER_CURSOR_EN
        if (cur3_q) rgb_d = cursor_color;
`endif
    end

    assign R            = rgb_q[23:16];
    assign G            = rgb_q[15:8];
    assign B            = rgb_q[7:0];
    assign vde_out      = vde_sr_q[LAT-1];
    assign hsync_out    = hs_sr_q[LAT-1];
    assign vsync_out    = vs_sr_q[LAT-1];
    assign current_tile = tile_q;

endmodule

// File: tb/tb_tile_renderer.sv
// Bench for tile_renderer: directed vectors, hand-timed corner cases and a randomised
// sweep against an arithmetic model of the tile/palette rules.
module tb_tile_renderer;
    logic         clk = 1'b0;
    logic         rst;
    logic [11:0]  x, y;
    logic         vde, hsync_in, vsync_in;
    logic         map_we;
    logic [10:0]  map_addr;
    logic [3:0]   map_wdata;
    logic         pal_we;
    logic [2:0]   pal_addr;
    logic [23:0]  pal_wdata;
    logic [8:0]   rom_addr;
    logic [95:0]  rom_data;
    logic [7:0]   R, G, B;
    logic         vde_out, hsync_out, vsync_out;
    logic [10:0]  current_tile;
`ifdef TILE_RENDERER_CURSOR_EN
    logic         cursor_en;
    logic [6:0]   cursor_col;
    logic [5:0]   cursor_row;
    logic [23:0]  cursor_color;
`endif

    tile_renderer dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .vde(vde),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .map_we(map_we), .map_addr(map_addr), .map_wdata(map_wdata),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_wdata(pal_wdata),
        .rom_addr(rom_addr), .rom_data(rom_data),
`ifdef TILE_RENDERER_CURSOR_EN
        .cursor_en(cursor_en), .cursor_col(cursor_col),
        .cursor_row(cursor_row), .cursor_color(cursor_color),
`endif
        .R(R), .G(G), .B(B),
        .vde_out(vde_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .current_tile(current_tile)
    );

    always #5 clk = ~clk;

    logic [95:0] rom_m [512];
    logic [3:0]  map_m [2048];
    logic [23:0] pal_m [8];

    always @(posedge clk) rom_data <= rom_m[rom_addr];

    int checks = 0;
    int errors = 0;

    typedef struct { logic [23:0] rgb; bit v; bit h; bit s; } exp_t;
    exp_t exp_q[$];

    typedef struct { int x; int y; bit v; bit h; bit s; logic [23:0] rgb; } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int xi, input int yi, input bit vi, input bit hi, input bit si);
        x = 12'(xi);
        y = 12'(yi);
        vde = vi;
        hsync_in = hi;
        vsync_in = si;
    endtask

    task automatic write_map(input int a, input int d);
        map_addr = 11'(a);
        map_wdata = 4'(d);
        map_we = 1'b1;
        tick();
        map_we = 1'b0;
        if (a < 60 * 34) map_m[a] = 4'(d);
    endtask

    task automatic write_pal(input int a, input logic [23:0] d);
        pal_addr = 3'(a);
        pal_wdata = d;
        pal_we = 1'b1;
        tick();
        pal_we = 1'b0;
        pal_m[a] = d;
    endtask

    task automatic reset_pal_model();
        for (int i = 0; i < 8; i++) pal_m[i] = 24'h000000;
        pal_m[1] = 24'h0000FF;
        pal_m[2] = 24'h00FF00;
        pal_m[4] = 24'hFF0000;
    endtask

    function automatic logic [23:0] model_rgb(input int xi, input int yi, input bit vi);
        int lx, ly, col, row, px, py, idx;
        logic [95:0] rd;
        if (!vi) return 24'h000000;
        lx = (xi - 192) & 8191;
        ly = (yi - 41 + 12) & 8191;
        col = lx / 32;
        row = ly / 32;
        px = lx % 32;
        py = ly % 32;
        if (col >= 60 || row >= 34) return 24'hFFFFFF;
`ifdef TILE_RENDERER_CURSOR_EN
        if (cursor_en && col == int'(cursor_col) && row == int'(cursor_row)
            && (px < 2 || px >= 30 || py < 2 || py >= 30))
            return cursor_color;
`endif
        rd = rom_m[int'(map_m[row * 60 + col]) * 32 + py];
        idx = int'((rd >> ((31 - px) * 3)) & 96'd7);
        return (idx == 0) ? 24'hFFFFFF : pal_m[idx];
    endfunction

    // Outputs seen after an edge belong to the inputs driven four ticks earlier.
    task automatic run_cycle(input string tag, input int xi, input int yi, input bit vi,
                             input bit hi, input bit si, input logic [23:0] er);
        exp_t e;
        tick();
        e = exp_q.pop_front();
        chk({tag, " rgb"}, 32'({R, G, B}), 32'(e.rgb));
        chk({tag, " sync"}, 32'({vde_out, hsync_out, vsync_out}), 32'({e.v, e.h, e.s}));
        drive(xi, yi, vi, hi, si);
        exp_q.push_back('{rgb: er, v: vi, h: hi, s: si});
    endtask

    task automatic sync_engine();
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        repeat (5) tick();
        exp_q.delete();
        repeat (4) exp_q.push_back('{rgb: 24'h0, v: 1'b0, h: 1'b0, s: 1'b0});
    endtask

    task automatic drain();
        repeat (4) run_cycle("drain", 0, 0, 1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    initial begin
        int ys[4];
        rst = 1'b1;
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        map_we = 1'b0; map_addr = '0; map_wdata = '0;
        pal_we = 1'b0; pal_addr = '0; pal_wdata = '0;
`ifdef TILE_RENDERER_CURSOR_EN
        cursor_en = 1'b0; cursor_col = '0; cursor_row = '0; cursor_color = '0;
`endif
        reset_pal_model();
        for (int i = 0; i < 512; i++) rom_m[i] = '0;
        for (int i = 0; i < 2048; i++) map_m[i] = '0;

        // Reset held while timing inputs toggle
        for (int i = 0; i < 8; i++) begin
            drive(192, 41, i[0], 1'b1, 1'b1);
            tick();
            chk("reset rgb", 32'({R, G, B}), 32'h0);
            chk("reset sync", 32'({vde_out, hsync_out, vsync_out}), 32'h0);
        end
        chk("reset tile", 32'(current_tile), 32'h0);
        chk("reset rom_addr", 32'(rom_addr), 32'h0);
        rst = 1'b0;
        drive(192, 41, 1'b1, 1'b1, 1'b1);
        repeat (3) tick();
        chk("latency 3 clk", 32'(vde_out), 32'h0);
        tick();
        chk("latency 4 clk", 32'({vde_out, hsync_out, vsync_out}), 32'h7);
        drive(0, 0, 1'b0, 1'b0, 1'b0);

        rom_m[1 * 32 + 12] = {32{3'b010}};
        rom_m[2 * 32 + 12] = {3'b100, 93'd0};
        write_map(0, 1);
        write_map(1, 2);

        vecs.push_back('{x: 192,  y: 41,   v: 1, h: 0, s: 0, rgb: 24'h00FF00});
        vecs.push_back('{x: 224,  y: 41,   v: 1, h: 1, s: 0, rgb: 24'hFF0000});
        vecs.push_back('{x: 225,  y: 41,   v: 1, h: 0, s: 1, rgb: 24'hFFFFFF});
        vecs.push_back('{x: 223,  y: 41,   v: 1, h: 1, s: 1, rgb: 24'h00FF00});
        vecs.push_back('{x: 2112, y: 41,   v: 1, h: 1, s: 1, rgb: 24'hFFFFFF});
        vecs.push_back('{x: 2112, y: 41,   v: 0, h: 1, s: 0, rgb: 24'h000000});
        vecs.push_back('{x: 100,  y: 41,   v: 1, h: 0, s: 0, rgb: 24'hFFFFFF});
        vecs.push_back('{x: 191,  y: 41,   v: 1, h: 0, s: 1, rgb: 24'hFFFFFF});
        vecs.push_back('{x: 192,  y: 1117, v: 1, h: 0, s: 0, rgb: 24'hFFFFFF});
        vecs.push_back('{x: 192,  y: 40,   v: 1, h: 1, s: 0, rgb: 24'hFFFFFF});
        vecs.push_back('{x: 192,  y: 28,   v: 1, h: 0, s: 0, rgb: 24'hFFFFFF});
        vecs.push_back('{x: 192,  y: 41,   v: 0, h: 0, s: 1, rgb: 24'h000000});
        sync_engine();
        foreach (vecs[i])
            run_cycle($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].v,
                      vecs[i].h, vecs[i].s, vecs[i].rgb);
        drain();

        drive(192, 41, 1'b1, 1'b0, 1'b0);
        repeat (4) tick();
        chk("hold rgb", 32'({R, G, B}), 32'h00FF00);
        chk("hold tile", 32'(current_tile), 32'h0);
        chk("hold rom_addr", 32'(rom_addr), 32'h2C);
        drive(352, 137, 1'b1, 1'b0, 1'b0);
        tick();
        chk("tile index", 32'(current_tile), 32'd185);
        drive(0, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        chk("tile hold vde0", 32'(current_tile), 32'd185);

        // Reset in the middle of active video
        drive(192, 41, 1'b1, 1'b1, 1'b0);
        repeat (5) tick();
        chk("pre-reset rgb", 32'({R, G, B}), 32'h00FF00);
        rst = 1'b1;
        #1;
        chk("midframe reset rgb", 32'({R, G, B}), 32'h0);
        chk("midframe reset sync", 32'({vde_out, hsync_out, vsync_out}), 32'h0);
        tick();
        rst = 1'b0;
        reset_pal_model();
        repeat (3) tick();
        chk("post-reset 3 clk", 32'({vde_out, R, G, B}), 32'h0);
        tick();
        chk("post-reset 4 clk", 32'({vde_out, R, G, B}), 32'h100FF00);

        write_pal(2, 24'h123456);
        repeat (3) tick();
        chk("pal write", 32'({R, G, B}), 32'h123456);
        pal_addr = 3'd2; pal_wdata = 24'hABCDEF; pal_we = 1'b1;
        tick();
        pal_we = 1'b0;
        pal_m[2] = 24'hABCDEF;
        chk("pal same edge", 32'({R, G, B}), 32'h123456);
        tick();
        chk("pal next edge", 32'({R, G, B}), 32'hABCDEF);

        // Map write colliding with the read of the same tile, plus a palette write
        map_addr = 11'd0; map_wdata = 4'd2; map_we = 1'b1;
        pal_addr = 3'd4; pal_wdata = 24'h445566; pal_we = 1'b1;
        tick();
        map_we = 1'b0; pal_we = 1'b0;
        map_m[0] = 4'd2; pal_m[4] = 24'h445566;
        chk("collide k", 32'({R, G, B}), 32'hABCDEF);
        tick();
        chk("collide k+1", 32'({R, G, B}), 32'hABCDEF);
        tick();
        chk("collide old data", 32'({R, G, B}), 32'hABCDEF);
        tick();
        chk("map+pal new", 32'({R, G, B}), 32'h445566);
        drive(0, 0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 512; i++) rom_m[i] = {$urandom, $urandom, $urandom};
        for (int a = 0; a < 60 * 34; a++) write_map(a, int'($urandom_range(0, 15)));
        for (int a = 0; a < 8; a++) write_pal(a, 24'($urandom));

`ifdef TILE_RENDERER_CURSOR_EN
        cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 6'd2; cursor_color = 24'hFF00FF;
        sync_engine();
        run_cycle("cursor corner", 288, 93, 1'b1, 1'b0, 1'b0, 24'hFF00FF);
        run_cycle("cursor right", 319, 100, 1'b1, 1'b0, 1'b0, 24'hFF00FF);
        run_cycle("cursor inner", 292, 99, 1'b1, 1'b0, 1'b0, model_rgb(292, 99, 1'b1));
        drain();
`endif

        sync_engine();
        for (int i = 0; i < 2000; i++) begin
            int xi, yi;
            bit vi;
            xi = int'($urandom_range(0, 2199));
            yi = int'($urandom_range(0, 1124));
            vi = ($urandom_range(0, 3) != 0);
            run_cycle("random", xi, yi, vi, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 1) == 1, model_rgb(xi, yi, vi));
        end
        drain();

        for (int l = 0; l < 4; l++) ys[l] = int'($urandom_range(41, 1124));
`ifdef TILE_RENDERER_CURSOR_EN
        cursor_col = 7'($urandom_range(0, 59));
        cursor_row = 6'(((ys[0] - 29) / 32) % 34);
        cursor_color = 24'($urandom);
`endif
        sync_engine();
        for (int l = 0; l < 4; l++) begin
            for (int xx = 0; xx < 2200; xx++) begin
                bit vi;
                vi = (xx >= 192 && xx < 2112);
                run_cycle("raster", xx, ys[l], vi, xx < 44, l == 0, model_rgb(xx, ys[l], vi));
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tile_renderer.md
Name: tile_renderer

Overview:
- Parametrised successor of the single-sprite pixel generator.
- Renders a full-screen grid of square tiles. Each tile shows one sprite selected from an on-chip tile map, which is written by the game/grid controller through a simple write port.
- Sprite pixels are palette indices. The palette is a writable register file, and index 0 is transparent (shows the background colour).
- Fully pipelined, one pixel per clock. Sync and vde are delayed to match the pixel path, so the block drops directly between the timing generator and the HDMI encoder.

Parameters:
- H_ACTIVE_START, 192, first active x (sync + back porch + border).
- V_ACTIVE_START, 41, first active y.
- Y_ADJ, 12, value added to the local y for vertical centring.
- TILE_LOG2, 5, log2 of the tile edge in pixels (32x32).
- N_COLS, 60, tiles per row.
- N_ROWS, 34, tile rows.
- MAP_AW, 11, tile-map address width (N_COLS*N_ROWS must be <= 2^MAP_AW).
- SPR_W, 4, sprite index width (16 sprites).
- BPP, 3, bits per sprite pixel (palette depth 2^BPP).
- BG_COLOR, 24'hFFFFFF, background RGB.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- x  in  12  timing-generator x
- y  in  12  timing-generator y
- vde  in  1  active video
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync
- map_we  in  1  tile-map write strobe
- map_addr  in  MAP_AW  tile index (row*N_COLS+col)
- map_wdata  in  SPR_W  sprite index
- pal_we  in  1  palette write strobe
- pal_addr  in  BPP  palette entry
- pal_wdata  in  24  RGB value
- rom_addr  out  SPR_W+TILE_LOG2  sprite ROM row address ({sprite, row})
- rom_data  in  BPP<<TILE_LOG2  ROM row data, 1-cycle read latency; leftmost pixel in the MSBs
- R, G, B  out  8 each  pixel colour
- vde_out, hsync_out, vsync_out  out  1 each  delayed timing signals
- current_tile  out  MAP_AW  tile index under the stage-0 pixel (for the grid controller)

Behaviour:
- Reset: R/G/B=0, vde_out/hsync_out/vsync_out=0, current_tile=0, rom_addr=0, all pipeline valids=0.
- Palette reset values: 0:000000, 1:0000FF, 2:00FF00, 3:000000, 4:FF0000, all others 000000.
- Tile map is not reset; contents are undefined until written.
- Reset asserted mid-frame clears the pipeline immediately. Outputs are black with syncs low until LAT clocks after reset release.
- Local coordinates: lx = x - H_ACTIVE_START; ly = y - V_ACTIVE_START + Y_ADJ. Both are 13 bits, unsigned.
- col = lx>>TILE_LOG2; row = ly>>TILE_LOG2.
- in_grid = vde & col<N_COLS & row<N_ROWS. Pixels not in_grid but with vde=1 output BG_COLOR; vde=0 outputs black.
- Pipeline, LAT=4 clocks from x/y/vde to R/G/B/vde_out:
  - S1: register col, row, pixel offsets, in_grid; current_tile = row*N_COLS+col.
  - S2: synchronous tile-map read.
  - S3: drive rom_addr = {sprite, ly[TILE_LOG2-1:0]}.
  - S4: select pixel field with rom_data[(2^TILE_LOG2-1-px)*BPP +: BPP]; do the palette lookup; register RGB.
- Pixel rule: index 0 -> BG_COLOR, else palette[index].
- hsync/vsync/vde are delayed by exactly LAT through shift registers.
- Map write/read collision on the same address in the same cycle: the read returns old data.
- Palette write: takes effect for any pixel reaching S4 on the following clock or later.
- Simultaneous map_we and pal_we are both honoured.
- Out-of-range map_addr (>= N_COLS*N_ROWS) is ignored.
- current_tile holds its last value while vde=0.

Optional Feature:
- Macro TILE_RENDERER_CURSOR_EN.
- With the macro defined, the block adds these inputs:
  - cursor_en (1)
  - cursor_col (7)
  - cursor_row (6)
  - cursor_color (24)
- When cursor_en=1, pixels on the outermost 2-pixel border of tile (cursor_row, cursor_col) output cursor_color, overriding the sprite and BG. Latency is unchanged.
- Without the macro, these ports and that logic do not exist.

Test Plan:
- Reset with vde toggling -> R/G/B=0 and syncs low throughout reset; the first valid pixel appears exactly 4 clocks after the first post-reset vde.
- Write map[0]=1; ROM sprite 1 row 12 all index 2; drive x=192, y=41 -> 4 clocks later RGB=00FF00, current_tile=0, rom_addr=0x2C.
- Write pal[2]=123456, then drive the same pixel -> RGB=123456. A pixel with index 0 -> FFFFFF.
- x=192+60*32 (col 60), vde=1 -> RGB=FFFFFF. Same x with vde=0 -> 000000 and vde_out=0.
- Full frame sweep with a random map -> hsync_out/vsync_out/vde_out equal the inputs delayed by 4 on every cycle, with no dropped pixels.
- With CURSOR_EN: cursor at (3,2), cursor_color=FF00FF -> pixel (lx=96, ly=64) is FF00FF, pixel (lx=100, ly=70) shows the sprite colour.
